qcw_ramp_sequencer: RTL and testbench



---
 rtl/qcw_pkg.sv | 29 ++
 rtl/qcw_phase_ramp.sv | 63 ++++++
 rtl/qcw_ramp_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_qcw_ramp_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qcw_pkg.sv
// Shared definitions for the QCW ramp sequencer and the bridge driver.
//   qcw_state_e  : sequencer FSM states
//   phase_q88_t  : 8.8 fixed-point phase accumulator type
//   PHASE_*_DEF  : default phase clamp limits shared with the driver
//   clamp_phase  : clamp an integer phase into [lo, hi]
package qcw_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARM      = 3'd1,
    RAMP     = 3'd2,
    HALTING  = 3'd3,
    COOLDOWN = 3'd4
  } qcw_state_e;

  typedef logic [15:0] phase_q88_t;

  localparam int unsigned PHASE_FLOOR_DEF = 50;
  localparam int unsigned PHASE_CEIL_DEF  = 254;

  function automatic logic [7:0] clamp_phase(input logic [7:0] v,
                                             input logic [7:0] lo,
                                             input logic [7:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/qcw_phase_ramp.sv
// Phase ramp datapath: 8.8 accumulator with saturating step toward the end
// phase, and the clamped 8-bit phase output.
//   clk, rst_n   : clock, async active-low reset
//   load         : load acc from start_phase, latch end_phase/slope
//   step         : advance acc by one slope increment
//   start_phase  : ramp start (integer phase)
//   end_phase    : ramp end (integer phase)
//   slope        : increment per step, unsigned 8.8
//   phase        : registered clamp(acc[15:8]), updated with acc
module qcw_phase_ramp
  import qcw_pkg::*;
#(
  parameter int unsigned PHASE_FLOOR = PHASE_FLOOR_DEF,
  parameter int unsigned PHASE_CEIL  = PHASE_CEIL_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  input  logic [7:0]  start_phase,
  input  logic [7:0]  end_phase,
  input  logic [15:0] slope,
  output logic [7:0]  phase
);

  phase_q88_t  acc;
  phase_q88_t  acc_nxt;
  phase_q88_t  tgt_q;
  phase_q88_t  slope_q;
  logic        hold_q;
  logic [16:0] sum;

  // Saturating step; a descending ramp request freezes acc at its start value
  always_comb begin
    sum     = {1'b0, acc} + {1'b0, slope_q};
    acc_nxt = acc;
    if (load) begin
      acc_nxt = {start_phase, 8'h00};
    end else if (step && !hold_q) begin
      acc_nxt = (sum > {1'b0, tgt_q}) ? tgt_q : sum[15:0];
    end
  end

  // Accumulator, latched ramp config and clamped phase register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      tgt_q   <= '0;
      slope_q <= '0;
      hold_q  <= 1'b0;
      phase   <= 8'(PHASE_FLOOR);
    end else begin
      acc   <= acc_nxt;
      phase <= clamp_phase(acc_nxt[15:8], 8'(PHASE_FLOOR), 8'(PHASE_CEIL));
      if (load) begin
        tgt_q   <= {end_phase, 8'h00};
        slope_q <= slope;
        hold_q  <= (end_phase < start_phase);
      end
    end
  end

endmodule

// File: rtl/qcw_ramp_sequencer.sv
// QCW shot sequencer: launches a driver shot on fire, ramps the driver phase
// shift once per bridge period, handles abort/halt, enforces a cooldown and
// reports shot status.
// Optional build macro: QCW_SEQ_WATCHDOG_EN adds a RAMP watchdog that aborts
// the shot when no drv_cycle_finished arrives for TIMEOUT_CLKS clocks.
//   clk, rst_n          : clock, async active-low reset
//   fire, abort         : shot request (IDLE only), level abort request
//   cfg_phase_start/end : ramp start/end phase, latched on fire
//   cfg_slope           : ramp step per period, 8.8, latched on fire
//   cfg_cycles          : shot length in bridge periods, latched on fire
//   drv_ready           : driver idle/ready
//   drv_cycle_finished  : driver one-clock period-done pulse
//   drv_start/halt      : driver start/halt requests
//   drv_phase_shift     : driver phase shift
//   drv_cycle_limit     : driver cycle limit
//   busy                : not in IDLE
//   shot_done           : one-clock pulse at shot end
//   shot_aborted        : last shot ended by abort/watchdog (sticky)
//   shot_count          : completed (non-aborted) shots, wrapping
module qcw_ramp_sequencer
  import qcw_pkg::*;
#(
  parameter int unsigned PHASE_FLOOR   = PHASE_FLOOR_DEF,
  parameter int unsigned PHASE_CEIL    = PHASE_CEIL_DEF,
  parameter int unsigned COOLDOWN_CLKS = 1000000,
  parameter int unsigned TIMEOUT_CLKS  = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fire,
  input  logic        abort,
  input  logic [7:0]  cfg_phase_start,
  input  logic [7:0]  cfg_phase_end,
  input  logic [15:0] cfg_slope,
  input  logic [15:0] cfg_cycles,
  input  logic        drv_ready,
  input  logic        drv_cycle_finished,
  output logic        drv_start,
  output logic        drv_halt,
  output logic [7:0]  drv_phase_shift,
  output logic [15:0] drv_cycle_limit,
  output logic        busy,
  output logic        shot_done,
  output logic        shot_aborted,
  output logic [15:0] shot_count
);

  localparam int unsigned CD_W = 24;

  qcw_state_e      state, state_nxt;
  logic [CD_W-1:0] cd_cnt, cd_cnt_nxt;
  logic            armed_seen, armed_seen_nxt;
  logic            drv_start_nxt, drv_halt_nxt, busy_nxt;
  logic            shot_done_nxt, shot_aborted_nxt;
  logic [15:0]     cycle_limit_nxt, shot_count_nxt;
  logic            ramp_load, ramp_step;
  logic            wd_trip;
  logic            abort_ev;

`ifdef QCW_SEQ_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CLKS + 1);
  logic [WD_W-1:0] wd_cnt;

  // Clocks since the last period boundary; held at zero outside RAMP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (state != RAMP || drv_cycle_finished) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  assign wd_trip = (state == RAMP) && (wd_cnt == WD_W'(TIMEOUT_CLKS - 1));
`else
  // TIMEOUT_CLKS kept so both builds share one parameter list
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT_CLKS == 0);
  assign wd_trip        = 1'b0;
`endif

  assign abort_ev = abort || wd_trip;

  qcw_phase_ramp #(
    .PHASE_FLOOR (PHASE_FLOOR),
    .PHASE_CEIL  (PHASE_CEIL)
  ) u_ramp (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (ramp_load),
    .step        (ramp_step),
    .start_phase (cfg_phase_start),
    .end_phase   (cfg_phase_end),
    .slope       (cfg_slope),
    .phase       (drv_phase_shift)
  );

  // Next-state and next-output logic
  always_comb begin
    state_nxt        = state;
    cd_cnt_nxt       = cd_cnt;
    armed_seen_nxt   = armed_seen;
    drv_start_nxt    = drv_start;
    drv_halt_nxt     = drv_halt;
    cycle_limit_nxt  = drv_cycle_limit;
    shot_done_nxt    = 1'b0;
    shot_aborted_nxt = shot_aborted;
    shot_count_nxt   = shot_count;
    ramp_load        = 1'b0;
    ramp_step        = 1'b0;

    unique case (state)
      IDLE: begin
        if (fire && !abort) begin
          state_nxt        = ARM;
          drv_start_nxt    = 1'b1;
          armed_seen_nxt   = 1'b0;
          cycle_limit_nxt  = cfg_cycles;
          shot_aborted_nxt = 1'b0;
          ramp_load        = 1'b1;
        end
      end
      ARM: begin
        // Start is accepted only on a ready 1->0 transition, so a driver
        // still busy from earlier work is waited out with start held
        if (drv_ready) armed_seen_nxt = 1'b1;
        if (abort) begin
          drv_start_nxt    = 1'b0;
          shot_aborted_nxt = 1'b1;
          if (drv_ready) begin
            state_nxt     = COOLDOWN;
            shot_done_nxt = 1'b1;
          end else begin
            state_nxt    = HALTING;
            drv_halt_nxt = 1'b1;
          end
        end else if (!drv_ready && armed_seen) begin
          drv_start_nxt = 1'b0;
          state_nxt     = RAMP;
        end
      end
      RAMP: begin
        if (abort_ev) begin
          shot_aborted_nxt = 1'b1;
          if (drv_ready) begin
            state_nxt     = COOLDOWN;
            shot_done_nxt = 1'b1;
          end else begin
            state_nxt    = HALTING;
            drv_halt_nxt = 1'b1;
          end
        end else begin
          ramp_step = drv_cycle_finished;
          if (drv_ready) begin
            state_nxt      = COOLDOWN;
            shot_done_nxt  = 1'b1;
            shot_count_nxt = shot_count + 16'd1;
          end
        end
      end
      HALTING: begin
        // Driver honours halt only while running; hold it until it is idle
        if (drv_ready) begin
          drv_halt_nxt  = 1'b0;
          shot_done_nxt = 1'b1;
          state_nxt     = COOLDOWN;
        end
      end
      COOLDOWN: begin
        if (cd_cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cd_cnt_nxt = cd_cnt - CD_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (state_nxt == COOLDOWN && state != COOLDOWN) begin
      cd_cnt_nxt = CD_W'(COOLDOWN_CLKS - 1);
    end
    busy_nxt = (state_nxt != IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cd_cnt          <= '0;
      armed_seen      <= 1'b0;
      drv_start       <= 1'b0;
      drv_halt        <= 1'b0;
      drv_cycle_limit <= '0;
      busy            <= 1'b0;
      shot_done       <= 1'b0;
      shot_aborted    <= 1'b0;
      shot_count      <= '0;
    end else begin
      state           <= state_nxt;
      cd_cnt          <= cd_cnt_nxt;
      armed_seen      <= armed_seen_nxt;
      drv_start       <= drv_start_nxt;
      drv_halt        <= drv_halt_nxt;
      drv_cycle_limit <= cycle_limit_nxt;
      busy            <= busy_nxt;
      shot_done       <= shot_done_nxt;
      shot_aborted    <= shot_aborted_nxt;
      shot_count      <= shot_count_nxt;
    end
  end

endmodule

// File: tb/tb_qcw_ramp_sequencer.sv
// Self-checking bench for qcw_ramp_sequencer with a behavioural bridge driver.
// Define QCW_SEQ_WATCHDOG_EN for both files to also exercise the watchdog.
module tb_qcw_ramp_sequencer;

  localparam int COOLDOWN = 100;
  localparam int TIMEOUT  = 64;
  localparam int FLOOR    = 50;
  localparam int CEIL     = 254;
  localparam int PERIOD   = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        fire = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  cfg_phase_start = '0;
  logic [7:0]  cfg_phase_end = '0;
  logic [15:0] cfg_slope = '0;
  logic [15:0] cfg_cycles = '0;
  logic        drv_ready = 1'b1;
  logic        drv_cycle_finished = 1'b0;
  logic        drv_start, drv_halt, busy, shot_done, shot_aborted;
  logic [7:0]  drv_phase_shift;
  logic [15:0] drv_cycle_limit, shot_count;

  int errors = 0;
  int checks = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  qcw_ramp_sequencer #(
    .COOLDOWN_CLKS (COOLDOWN),
    .TIMEOUT_CLKS  (TIMEOUT)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .fire               (fire),
    .abort              (abort),
    .cfg_phase_start    (cfg_phase_start),
    .cfg_phase_end      (cfg_phase_end),
    .cfg_slope          (cfg_slope),
    .cfg_cycles         (cfg_cycles),
    .drv_ready          (drv_ready),
    .drv_cycle_finished (drv_cycle_finished),
    .drv_start          (drv_start),
    .drv_halt           (drv_halt),
    .drv_phase_shift    (drv_phase_shift),
    .drv_cycle_limit    (drv_cycle_limit),
    .busy               (busy),
    .shot_done          (shot_done),
    .shot_aborted       (shot_aborted),
    .shot_count         (shot_count)
  );

  // Bridge driver model: accepts start after seeing it on two clocks, runs
  // PERIOD-clock bridge periods up to the cycle limit, stops at once on halt.
  bit stall = 1'b0;
  bit running = 1'b0;
  bit start_seen = 1'b0;
  int pcnt = 0;
  int ccnt = 0;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drv_ready = 1'b1; drv_cycle_finished = 1'b0;
      running = 1'b0; start_seen = 1'b0; pcnt = 0; ccnt = 0;
    end else begin
      drv_cycle_finished = 1'b0;
      if (!running) begin
        if (drv_start && start_seen) begin
          running = 1'b1; drv_ready = 1'b0; pcnt = 0; ccnt = 0; start_seen = 1'b0;
        end else begin
          start_seen = drv_start;
        end
      end else if (drv_halt) begin
        running = 1'b0; drv_ready = 1'b1;
      end else if (!stall) begin
        pcnt++;
        if (pcnt == PERIOD) begin
          pcnt = 0; ccnt++; drv_cycle_finished = 1'b1;
          if (ccnt >= int'(drv_cycle_limit)) begin
            running = 1'b0; drv_ready = 1'b1;
          end
        end
      end
    end
  end

  // Expected phase after k period boundaries, straight from the ramp rules
  function automatic int model_phase(int s, int e, int sl, int k);
    int a;
    int p;
    if (e < s) a = s * 256;
    else begin
      a = s * 256 + k * sl;
      if (a > e * 256) a = e * 256;
    end
    p = a / 256;
    if (p < FLOOR) p = FLOOR;
    if (p > CEIL) p = CEIL;
    return p;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 1000) begin tick(); n++; end
    check({tag, " idle"}, 32'(busy), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " start"}, 32'(drv_start), 0);
    check({tag, " halt"}, 32'(drv_halt), 0);
    check({tag, " phase"}, 32'(drv_phase_shift), FLOOR);
    check({tag, " limit"}, 32'(drv_cycle_limit), 0);
    check({tag, " busy"}, 32'(busy), 0);
    check({tag, " done"}, 32'(shot_done), 0);
    check({tag, " aborted"}, 32'(shot_aborted), 0);
    check({tag, " count"}, 32'(shot_count), 0);
  endtask

  task automatic launch(input int s, input int e, input int sl, input int cyc);
    cfg_phase_start = 8'(s); cfg_phase_end = 8'(e);
    cfg_slope = 16'(sl); cfg_cycles = 16'(cyc);
    fire = 1'b1;
    tick();
    fire = 1'b0;
  endtask

  // One full shot; ab>0 aborts right after the ab-th period boundary
  task automatic run_shot(input string tag, input int s, input int e, input int sl,
                          input int cyc, input int ab, input int exp_ph, input bit exp_ab);
    int k = 0;
    int dones = 0;
    int post = 0;
    bit abort_sent = 1'b0;
    bit halt_seen = 1'b0;
    bit done = 1'b0;
    wait_idle(tag);
    launch(s, e, sl, cyc);
    check({tag, " start"}, 32'(drv_start), 1);
    check({tag, " limit"}, 32'(drv_cycle_limit), 32'(cyc));
    check({tag, " ph0"}, 32'(drv_phase_shift), 32'(model_phase(s, e, sl, 0)));
    check({tag, " abclr"}, 32'(shot_aborted), 0);
    for (int n = 0; n < 3000; n++) begin
      tick();
      if (drv_halt) halt_seen = 1'b1;
      if (drv_cycle_finished && !abort_sent && !done) begin
        k++;
        check({tag, " ph"}, 32'(drv_phase_shift), 32'(model_phase(s, e, sl, k)));
      end
      if (shot_done) begin dones++; done = 1'b1; end
      if (ab != 0 && k == ab && !abort_sent) begin abort = 1'b1; abort_sent = 1'b1; end
      if (done) post++;
      if (post > 4) break;
    end
    abort = 1'b0;
    if (!exp_ab) exp_count = (exp_count + 1) % 65536;
    check({tag, " finished"}, 32'(done), 1);
    check({tag, " dones"}, 32'(dones), 1);
    check({tag, " steps"}, 32'(k), 32'((ab != 0) ? ab : cyc));
    check({tag, " phend"}, 32'(drv_phase_shift), 32'(exp_ph));
    check({tag, " aborted"}, 32'(shot_aborted), 32'(exp_ab));
    check({tag, " count"}, 32'(shot_count), 32'(exp_count));
    check({tag, " halt_seen"}, 32'(halt_seen), 32'(ab != 0));
    check({tag, " halt_off"}, 32'(drv_halt), 0);
  endtask

  typedef struct {
    int s;
    int e;
    int sl;
    int cyc;
    int ab;
    int ph;
    bit aborted;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #5_000_000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    int dn;
    int s, e, sl, cyc, ab;

    tbl[0] = '{s: 60,  e: 200, sl: 'h1000, cyc: 20, ab: 0, ph: 200, aborted: 1'b0};
    tbl[1] = '{s: 10,  e: 255, sl: 'hFF00, cyc: 4,  ab: 0, ph: 254, aborted: 1'b0};
    tbl[2] = '{s: 200, e: 100, sl: 'h1000, cyc: 6,  ab: 0, ph: 200, aborted: 1'b0};
    tbl[3] = '{s: 60,  e: 200, sl: 'h1000, cyc: 20, ab: 5, ph: 140, aborted: 1'b1};
    tbl[4] = '{s: 100, e: 120, sl: 'h0080, cyc: 10, ab: 0, ph: 105, aborted: 1'b0};
    tbl[5] = '{s: 0,   e: 40,  sl: 'h0100, cyc: 8,  ab: 0, ph: 50,  aborted: 1'b0};
    tbl[6] = '{s: 250, e: 255, sl: 'h0040, cyc: 3,  ab: 2, ph: 250, aborted: 1'b1};

    #1 rst_n = 1'b0;
    #2 check_reset_outputs("reset");
    #19 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      run_shot($sformatf("vec%0d", i), tbl[i].s, tbl[i].e, tbl[i].sl, tbl[i].cyc,
               tbl[i].ab, tbl[i].ph, tbl[i].aborted);
    end

    for (int i = 0; i < 10; i++) begin
      s = int'($urandom_range(0, 255));
      e = int'($urandom_range(0, 255));
      sl = int'($urandom_range(0, 65535));
      cyc = int'($urandom_range(2, 12));
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, cyc - 1)) : 0;
      run_shot($sformatf("rnd%0d", i), s, e, sl, cyc, ab,
               model_phase(s, e, sl, (ab != 0) ? ab : cyc), ab != 0);
    end

    // Abort in ARM before the driver leaves idle, then cooldown with fire held
    wait_idle("armab");
    launch(60, 200, 'h1000, 20);
    check("armab start", 32'(drv_start), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("armab start_drop", 32'(drv_start), 0);
    check("armab halt", 32'(drv_halt), 0);
    check("armab done", 32'(shot_done), 1);
    check("armab aborted", 32'(shot_aborted), 1);
    check("armab busy", 32'(busy), 1);
    check("armab count", 32'(shot_count), 32'(exp_count));
    fire = 1'b1;
    c = 0;
    dn = 0;
    do begin
      tick();
      c++;
      if (shot_done) dn++;
    end while (!drv_start && c < 500);
    fire = 1'b0;
    check("cooldown latency", 32'(c), COOLDOWN + 1);
    check("cooldown extra_done", 32'(dn), 0);
    check("cooldown drv_ready", 32'(drv_ready), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("armab2 start_drop", 32'(drv_start), 0);

    // fire together with abort in IDLE is ignored
    wait_idle("fireab");
    fire = 1'b1;
    abort = 1'b1;
    tick();
    fire = 1'b0;
    abort = 1'b0;
    check("fireab start", 32'(drv_start), 0);
    check("fireab busy", 32'(busy), 0);

`ifdef QCW_SEQ_WATCHDOG_EN
    // Driver stops producing period boundaries mid-ramp
    wait_idle("wdog");
    launch(60, 200, 'h1000, 20);
    c = 0;
    dn = 0;
    while (dn < 2 && c < 500) begin
      tick();
      c++;
      if (drv_cycle_finished) dn++;
    end
    stall = 1'b1;
    c = 0;
    do begin
      tick();
      c++;
    end while (!drv_halt && c < 200);
    check("wdog halt_clock", 32'(c), TIMEOUT);
    c = 0;
    while (!shot_done && c < 50) begin tick(); c++; end
    stall = 1'b0;
    check("wdog done", 32'(shot_done), 1);
    check("wdog aborted", 32'(shot_aborted), 1);
    check("wdog count", 32'(shot_count), 32'(exp_count));
`endif

    // Asynchronous reset in the middle of a ramp
    wait_idle("rstmid");
    launch(60, 200, 'h1000, 20);
    c = 0;
    dn = 0;
    while (dn < 3 && c < 500) begin
      tick();
      c++;
      if (drv_cycle_finished) dn++;
    end
    check("rstmid busy", 32'(busy), 1);
    check("rstmid phase", 32'(drv_phase_shift), 108);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rstmid");
    #10 rst_n = 1'b1;
    exp_count = 0;
    tick();
    tick();
    check("rstmid after busy", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
